nios_ocimem_arbiter: RTL and testbench
======================================

Name: nios_ocimem_arbiter

Overview:
- Sequences and shares the on-chip debug memory (OCI RAM, 2**ADDR_W x DATA_W, single port, 1-cycle read latency) between two requesters:
  - the JTAG debug path: take_action_ocimem_* pulses plus jdo, from the debug-slave sysclk domain;
  - the CPU's Avalon debug slave port.
- Owns the JTAG auto-incrementing address register and the MonDReg capture register.
- Sits between the debug-slave wrapper and the OCI RAM inside the Nios CPU.

Parameters:
- ADDR_W, 8, OCI RAM word address width.
- DATA_W, 32, RAM/Avalon data width; must be 32 (jdo packing is fixed).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  JTAG data-out word, stable during take_action pulses.
- take_action_ocimem_a  in  1  1-cycle pulse: load address jdo[25:18]; if jdo[35]=1 also launch a read.
- take_no_action_ocimem_a  in  1  1-cycle pulse: read at current address, then increment.
- take_action_ocimem_b  in  1  1-cycle pulse: write jdo[34:3] at current address (all bytes), then increment.
- avs_address  in  ADDR_W  Avalon word address.
- avs_read  in  1  Avalon read request.
- avs_write  in  1  Avalon write request.
- avs_writedata  in  32  Avalon write data.
- avs_byteenable  in  4  Avalon byte enables.
- avs_waitrequest  out  1  Avalon stall.
- avs_readdata  out  32  Avalon read data, valid when read accepted.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_be  out  4  RAM byte enables.
- ram_we  out  1  RAM write strobe.
- ram_rdata  in  32  RAM read data, one cycle after address.
- MonDReg  out  32  last JTAG read data.
- mon_ready  out  1  1-cycle pulse when MonDReg updated by a JTAG read.
- jtag_overrun  out  1  sticky: JTAG command lost.

Behaviour:
- Reset values (asynchronous, reset_n low):
  - outputs: MonDReg=0, avs_readdata=0, mon_ready=0, jtag_overrun=0, ram_we=0, ram_addr=0, avs_waitrequest=1.
  - internal: FSM=IDLE, jaddr=0, pending cleared, last_grant=AVS.
- JTAG pending latch (1 deep): captures command type, address and data on any take_action pulse.
  - Pulse while the latch is already full: new command dropped, jtag_overrun<=1.
  - take_action_ocimem_a always updates jaddr (never dropped) and clears jtag_overrun in the same cycle.
- FSM states: IDLE, J_RD, J_CAP, J_WR, A_RD, A_CAP, A_WR.
  - IDLE: if JTAG pending and Avalon requesting, grant alternates by last_grant (round-robin); otherwise grant whichever requests.
  - J_RD: ram_addr=jaddr. Next J_CAP.
  - J_CAP: MonDReg<=ram_rdata, mon_ready=1, jaddr<=jaddr+1 (wraps mod 2**ADDR_W), pending cleared. Next IDLE.
  - J_WR: ram_we=1, ram_be=4'hF, ram_wdata=latched jdo[34:3], jaddr<=jaddr+1, pending cleared. Next IDLE.
  - A_RD: ram_addr=avs_address. Next A_CAP.
  - A_CAP: avs_readdata<=ram_rdata, avs_waitrequest=0 this cycle. Next IDLE.
  - A_WR: ram_we=1, ram_be=avs_byteenable, avs_waitrequest=0. Next IDLE.
- A load-only ocimem_a (jdo[35]=0) performs no RAM access and needs no grant.
- Latency with no contention:
  - JTAG read pulse at cycle N: ram_addr at N+1, mon_ready at N+2.
  - Avalon read asserted at N: waitrequest low at N+2.
  - Avalon write asserted at N: waitrequest low at N+1.
- avs_waitrequest is 1 except in A_CAP and A_WR. Avalon inputs must be held stable while waitrequest=1.
- ocimem_a pulse arriving during J_RD/J_CAP of a prior read:
  - jaddr is reloaded;
  - J_CAP's increment is overridden by the load;
  - the new read queues normally.
- Reset asserted mid-operation: everything returns to reset values immediately; an in-flight write strobe is deasserted.

Optional Feature:
- Macro: OCIMEM_ROM_PROTECT_EN.
- Defined:
  - Avalon writes with avs_address[ADDR_W-1]=1 (upper half, debug ROM) complete the handshake (A_WR, waitrequest low) but ram_we stays 0.
  - JTAG writes are unaffected.
- Undefined: all Avalon writes reach the RAM.

Test Plan:
- Write then read back over JTAG:
  - ocimem_a with jdo[25:18]=8'h10, jdo[35]=0; then ocimem_b with data 32'hDEADBEEF; expect ram_we at addr 8'h10, jaddr=8'h11.
  - ocimem_a to 8'h10 with jdo[35]=1; expect mon_ready 2 cycles later, MonDReg=32'hDEADBEEF.
- Wrap-around: jaddr=8'hFF, take_no_action_ocimem_a; expect read at 8'hFF, then jaddr=8'h00.
- Simultaneous requests: JTAG read and Avalon read pending in the same cycle with last_grant=AVS; expect JTAG served first, Avalon waitrequest low 2 cycles after JTAG completes.
- Overrun: two ocimem_b pulses 1 cycle apart while an Avalon read is in A_RD; expect jtag_overrun=1 and only the first write performed; a subsequent ocimem_a clears jtag_overrun.
- Avalon byte write: avs_write to 8'h05, be=4'b0010, data 32'h0000AB00; expect ram_be=4'b0010 and waitrequest low 1 cycle later. With OCIMEM_ROM_PROTECT_EN, the same write to 8'h85 gives ram_we=0 but the handshake still completes.
- Reset mid-J_WR: assert reset_n=0 during J_WR; expect ram_we=0 immediately, and MonDReg=0, jaddr=0 after release.

Source files
------------

// File: rtl/nios_ocimem_arbiter.sv
// rtl/nios_ocimem_arbiter.sv - OCI RAM sharing between JTAG debug commands and the Avalon debug slave; optional OCIMEM_ROM_PROTECT_EN
module nios_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] avs_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              mon_ready,
    output logic              jtag_overrun
);

    typedef enum logic [2:0] {IDLE, J_RD, J_CAP, J_WR, A_RD, A_CAP, A_WR} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   jaddr;
    logic                pend_valid;
    logic                pend_wr;
    logic [DATA_W-1:0]   pend_data;
    logic                last_grant_avs;
    logic                skip_inc;

    logic                new_rd, new_wr, new_req;
    logic                j_req, j_is_wr, a_req;
    logic [DATA_W-1:0]   j_data;
    logic                grant_j, grant_a;
    logic                load_pend, drop_cmd;
    logic [ADDR_W-1:0]   jaddr_d;
    logic                avs_we;
    logic                unused_jdo;

    assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

    assign new_rd  = (take_action_ocimem_a & jdo[35]) | take_no_action_ocimem_a;
    assign new_wr  = take_action_ocimem_b;
    assign new_req = new_rd | new_wr;

    // A latched command always predates a fresh pulse, so it is served first.
    assign j_req   = pend_valid | new_req;
    assign j_is_wr = pend_valid ? pend_wr : new_wr;
    assign j_data  = pend_valid ? pend_data : jdo[34:3];
    assign a_req   = avs_read | avs_write;

    assign grant_j = (state == IDLE) && j_req && (!a_req || last_grant_avs);
    assign grant_a = (state == IDLE) && a_req && !grant_j;

    // The latch frees on grant; a fresh pulse either bypasses it, fills it, or is lost.
    assign load_pend = new_req && (pend_valid == grant_j);
    assign drop_cmd  = new_req && pend_valid && !grant_j;

`ifdef OCIMEM_ROM_PROTECT_EN
    assign avs_we = ~avs_address[ADDR_W-1];
`else
    assign avs_we = 1'b1;
`endif

    always_comb begin
        jaddr_d = jaddr;
        if (take_action_ocimem_a)
            jaddr_d = ADDR_W'(jdo[25:18]);
        else if ((state == J_CAP && !skip_inc) || state == J_WR)
            jaddr_d = jaddr + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            jaddr           <= '0;
            pend_valid      <= 1'b0;
            pend_wr         <= 1'b0;
            pend_data       <= '0;
            last_grant_avs  <= 1'b1;
            skip_inc        <= 1'b0;
            jtag_overrun    <= 1'b0;
            MonDReg         <= '0;
            mon_ready       <= 1'b0;
            avs_readdata    <= '0;
            avs_waitrequest <= 1'b1;
            ram_addr        <= '0;
            ram_wdata       <= '0;
            ram_be          <= '0;
            ram_we          <= 1'b0;
        end else begin
            jaddr           <= jaddr_d;
            ram_we          <= 1'b0;
            mon_ready       <= 1'b0;
            avs_waitrequest <= 1'b1;

            if (take_action_ocimem_a)
                jtag_overrun <= 1'b0;
            else if (drop_cmd)
                jtag_overrun <= 1'b1;

            if (load_pend) begin
                pend_valid <= 1'b1;
                pend_wr    <= new_wr;
                pend_data  <= jdo[34:3];
            end else if (grant_j) begin
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant_j) begin
                        last_grant_avs <= 1'b0;
                        ram_addr       <= jaddr_d;
                        if (j_is_wr) begin
                            state     <= J_WR;
                            ram_we    <= 1'b1;
                            ram_be    <= 4'hF;
                            ram_wdata <= j_data;
                        end else begin
                            state <= J_RD;
                        end
                    end else if (grant_a) begin
                        last_grant_avs <= 1'b1;
                        ram_addr       <= avs_address;
                        if (avs_write) begin
                            state           <= A_WR;
                            ram_we          <= avs_we;
                            ram_be          <= avs_byteenable;
                            ram_wdata       <= avs_writedata;
                            avs_waitrequest <= 1'b0;
                        end else begin
                            state <= A_RD;
                        end
                    end
                end
                J_RD: begin
                    state     <= J_CAP;
                    mon_ready <= 1'b1;
                    // A reload landing here must survive the capture-cycle increment.
                    skip_inc  <= take_action_ocimem_a;
                end
                J_CAP: begin
                    MonDReg  <= ram_rdata;
                    skip_inc <= 1'b0;
                    state    <= IDLE;
                end
                J_WR: state <= IDLE;
                A_RD: begin
                    state           <= A_CAP;
                    avs_waitrequest <= 1'b0;
                end
                A_CAP: begin
                    avs_readdata <= ram_rdata;
                    state        <= IDLE;
                end
                A_WR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_ocimem_arbiter.sv
// tb/tb_nios_ocimem_arbiter.sv - directed scoreboard bench for nios_ocimem_arbiter
module tb_nios_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        mon_ready;
    logic        jtag_overrun;

    always #5 clk = ~clk;

    nios_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .MonDReg(MonDReg), .mon_ready(mon_ready),
        .jtag_overrun(jtag_overrun)
    );

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] jq [$];
    logic [31:0] aq [$];
    logic [31:0] wr_word;
    int passed = 0;
    int total  = 0;
    int n;
    bit mon_pend = 0;
    bit avs_pend = 0;

    always @(posedge clk) begin
        wr_word = mem[ram_addr];
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) wr_word[8*b +: 8] = ram_wdata[8*b +: 8];
        if (ram_we) mem[ram_addr] <= wr_word;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_pend = 0;
            avs_pend = 0;
        end else begin
            if (mon_pend)
                check("mondreg", MonDReg, (jq.size() > 0) ? jq.pop_front() : 32'hBAD0BAD0);
            if (avs_pend)
                check("avs_readdata", avs_readdata, (aq.size() > 0) ? aq.pop_front() : 32'hBAD0BAD0);
            mon_pend = mon_ready;
            avs_pend = !avs_waitrequest && avs_read;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic pulse_a(input bit rd, input logic [7:0] addr);
        jdo = '0;
        jdo[35] = rd;
        jdo[25:18] = addr;
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] data);
        jdo = '0;
        jdo[34:3] = data;
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic pulse_n();
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic avs_rd(input logic [7:0] addr);
        int k;
        avs_address = addr;
        avs_read = 1'b1;
        aq.push_back(ref_mem[addr]);
        k = 1;
        step();
        while (avs_waitrequest && k < 20) begin
            step();
            k++;
        end
        check("avs_rd_latency", 32'(k), 32'd2);
        step();
        avs_read = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = {8'hA5, 8'(i), ~8'(i), 8'(i * 3)};
            ref_mem[i] = {8'hA5, 8'(i), ~8'(i), 8'(i * 3)};
        end
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
        avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_avs_readdata", avs_readdata, 32'h0);
        check("rst_mon_ready", 32'(mon_ready), 32'd0);
        check("rst_overrun", 32'(jtag_overrun), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_waitreq", 32'(avs_waitrequest), 32'd1);
        reset_n = 1'b1;
        idle(2);

        // JTAG write then read back
        pulse_a(0, 8'h10);
        check("load_only_no_we", 32'(ram_we), 32'd0);
        step();
        check("load_only_no_ready", 32'(mon_ready), 32'd0);
        pulse_b(32'hDEADBEEF);
        check("jwr_we", 32'(ram_we), 32'd1);
        check("jwr_addr", 32'(ram_addr), 32'h10);
        check("jwr_be", 32'(ram_be), 32'hF);
        check("jwr_data", ram_wdata, 32'hDEADBEEF);
        ref_mem[8'h10] = 32'hDEADBEEF;
        step();
        check("jwr_we_drop", 32'(ram_we), 32'd0);
        step();
        pulse_n();
        check("jaddr_after_write", 32'(ram_addr), 32'h11);
        jq.push_back(ref_mem[8'h11]);
        step();
        check("jrd_ready_n", 32'(mon_ready), 32'd1);
        idle(2);
        pulse_a(1, 8'h10);
        jq.push_back(ref_mem[8'h10]);
        check("jrd_addr_n1", 32'(ram_addr), 32'h10);
        check("jrd_ready_n1", 32'(mon_ready), 32'd0);
        step();
        check("jrd_ready_n2", 32'(mon_ready), 32'd1);
        idle(2);

        // address wrap
        pulse_a(0, 8'hFF);
        step();
        pulse_n();
        check("wrap_rd_ff", 32'(ram_addr), 32'hFF);
        jq.push_back(ref_mem[8'hFF]);
        idle(3);
        pulse_n();
        check("wrap_rd_00", 32'(ram_addr), 32'h00);
        jq.push_back(ref_mem[8'h00]);
        idle(3);

        // Avalon byte write
        avs_address = 8'h05; avs_byteenable = 4'b0010; avs_writedata = 32'h0000AB00; avs_write = 1'b1;
        step();
        check("awr_waitreq", 32'(avs_waitrequest), 32'd0);
        check("awr_we", 32'(ram_we), 32'd1);
        check("awr_be", 32'(ram_be), 32'h2);
        check("awr_addr", 32'(ram_addr), 32'h05);
        ref_mem[8'h05][15:8] = 8'hAB;
        step();
        avs_write = 1'b0;
        check("awr_waitreq_back", 32'(avs_waitrequest), 32'd1);
        step();

        // Avalon write into upper half
        avs_address = 8'h85; avs_byteenable = 4'hF; avs_writedata = 32'h12345678; avs_write = 1'b1;
        step();
        check("rom_waitreq", 32'(avs_waitrequest), 32'd0);
`ifdef OCIMEM_ROM_PROTECT_EN
        check("rom_we_blocked", 32'(ram_we), 32'd0);
`else
        check("rom_we_open", 32'(ram_we), 32'd1);
        ref_mem[8'h85] = 32'h12345678;
`endif
        step();
        avs_write = 1'b0;
        step();
        avs_rd(8'h85);
        idle(2);

        // simultaneous requests, last grant was Avalon
        avs_address = 8'h05; avs_read = 1'b1;
        aq.push_back(ref_mem[8'h05]);
        take_no_action_ocimem_a = 1'b1;
        jq.push_back(ref_mem[8'h01]);
        step();
        take_no_action_ocimem_a = 1'b0;
        check("sim_jtag_first", 32'(ram_addr), 32'h01);
        check("sim_avs_waits", 32'(avs_waitrequest), 32'd1);
        step();
        check("sim_jtag_ready", 32'(mon_ready), 32'd1);
        n = 0;
        while (avs_waitrequest && n < 20) begin
            step();
            n++;
        end
        check("sim_avs_after_jtag", 32'(n), 32'd3);
        step();
        avs_read = 1'b0;
        idle(2);

        // overrun during an Avalon read
        avs_address = 8'h10; avs_read = 1'b1;
        aq.push_back(ref_mem[8'h10]);
        step();
        check("ovr_ard_wait", 32'(avs_waitrequest), 32'd1);
        jdo = '0; jdo[34:3] = 32'h11112222; take_action_ocimem_b = 1'b1;
        step();
        check("ovr_acap_wait", 32'(avs_waitrequest), 32'd0);
        jdo = '0; jdo[34:3] = 32'h33334444;
        step();
        take_action_ocimem_b = 1'b0; avs_read = 1'b0;
        check("ovr_flag_set", 32'(jtag_overrun), 32'd1);
        step();
        check("ovr_wr_we", 32'(ram_we), 32'd1);
        check("ovr_wr_data", ram_wdata, 32'h11112222);
        check("ovr_wr_addr", 32'(ram_addr), 32'h02);
        ref_mem[8'h02] = 32'h11112222;
        n = 0;
        repeat (4) begin
            step();
            if (ram_we) n++;
        end
        check("ovr_single_write", 32'(n), 32'd0);
        pulse_a(0, 8'h02);
        check("ovr_flag_clear", 32'(jtag_overrun), 32'd0);
        step();
        pulse_a(1, 8'h02);
        jq.push_back(ref_mem[8'h02]);
        idle(3);

        // reload during J_RD overrides the capture increment
        pulse_n();
        check("reload_first_addr", 32'(ram_addr), 32'h03);
        jq.push_back(ref_mem[8'h03]);
        pulse_a(1, 8'h20);
        jq.push_back(ref_mem[8'h20]);
        check("reload_first_ready", 32'(mon_ready), 32'd1);
        idle(2);
        check("reload_queued_addr", 32'(ram_addr), 32'h20);
        step();
        check("reload_queued_ready", 32'(mon_ready), 32'd1);
        idle(2);
        pulse_n();
        check("reload_next_addr", 32'(ram_addr), 32'h21);
        jq.push_back(ref_mem[8'h21]);
        idle(3);

        // reset in the middle of a JTAG write
        pulse_b(32'hCAFEF00D);
        check("rstwr_we_before", 32'(ram_we), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rstwr_we_async", 32'(ram_we), 32'd0);
        check("rstwr_waitreq", 32'(avs_waitrequest), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        check("rstwr_mondreg", MonDReg, 32'h0);
        pulse_n();
        check("rstwr_jaddr_zero", 32'(ram_addr), 32'h00);
        jq.push_back(ref_mem[8'h00]);
        idle(4);

        check("jq_drained", 32'(jq.size()), 32'd0);
        check("aq_drained", 32'(aq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
